dispatch_queue: RTL and testbench
=================================

DISPATCH_QUEUE -- requirements
Module: dispatch_queue

Interface
REQ-001 Parameter QUEUE_DEPTH, default 4, entry count of the instruction holding queue; power of two, at least 2.
REQ-002 Parameter PAYLOAD_W, default 64, width of the opaque per-instruction payload (instruction word and PC).
REQ-003 Parameter TAG_W, default 4, ROB tag width.
REQ-004 clk  in  1  single clock; all state on its rising edge.
REQ-005 rst  in  1  reset, asynchronous, active-low.
REQ-006 rdy  in  1  global enable; when 0, no state changes and all enables are 0.
REQ-007 flush  in  1  ROB rollback; discards queue contents.
REQ-008 ifetch_valid  in  1  fetcher offers an instruction.
REQ-009 ifetch_optype  in  6  decoded op type, using the shared op-type encoding.
REQ-010 ifetch_payload  in  PAYLOAD_W  instruction payload.
REQ-011 ifetch_ready  out  1  queue can accept this cycle.
REQ-012 ROB_full, RS_full, LSB_full  in  1 each  downstream occupancy.
REQ-013 ROB_nextTag  in  TAG_W  tag the ROB assigns next.
REQ-014 ROB_enable, reg_rename_enable, RS_enable, LSB_enable  out  1 each  issue strobes.
REQ-015 issue_rdTag  out  TAG_W  tag for rename; equals ROB_nextTag when issuing, else 0.
REQ-016 issue_optype  out  6, issue_payload  out  PAYLOAD_W  head-entry contents.

Function
REQ-017 The queue SHALL be a circular FIFO with head/tail pointers of log2(QUEUE_DEPTH) bits, wrapping modulo QUEUE_DEPTH, plus a count of log2(QUEUE_DEPTH)+1 bits.
REQ-018 ifetch_ready SHALL be 1 iff count < QUEUE_DEPTH, rst is high, rdy=1 and flush=0, derived only from registered state and these inputs, with no path from the full flags.
REQ-019 A push SHALL occur when ifetch_valid and ifetch_ready are both 1; it writes optype and payload at tail.
REQ-020 Head class: LSB if LB <= optype <= SW, otherwise RS.
REQ-021 An issue SHALL occur when count>0, rdy=1, flush=0, ROB_full=0, and the full flag of the head's class is 0; it asserts ROB_enable, reg_rename_enable, and exactly one of RS_enable/LSB_enable, combinationally in that cycle, then advances head.
REQ-022 At most one push and one issue per cycle; a simultaneous push and issue leaves count unchanged. When full, a push is refused even if an issue occurs.
REQ-023 A stalled head blocks younger entries; issue is strictly in order.
REQ-024 Latency without bypass: an instruction pushed in cycle N is issuable no earlier than cycle N+1.
REQ-025 flush=1 SHALL clear count, head and tail at the next edge, suppress issue, and refuse the push in that cycle.
REQ-026 issue_optype and issue_payload SHALL show the head entry (or the bypassed input) whenever an issue strobe is high; they are don't-care otherwise.

Reset
REQ-027 While rst=0: count, head and tail are 0; all enables, ifetch_ready and issue_rdTag are 0.
REQ-028 Reset asserted mid-operation SHALL drop all queued entries immediately, with no issue strobe in that cycle.

Configuration
REQ-029 Macro DISPATCH_BYPASS_EN: when defined, if count=0 and the input is pushable and issuable per REQ-021, it SHALL issue in the same cycle without being written to the queue (zero latency). When undefined, REQ-024 always holds.

Structure
REQ-030 The op-type codes (LB, SW and the rest), True/False and the ROB tag range SHALL come from the shared defines package; QUEUE_DEPTH default lives there too.
REQ-031 Sub-module: dispatch_fifo (storage, pointers, count); classification and issue logic sit in dispatch_queue.

Verification
REQ-032 Depth 4, five back-to-back LOAD pushes with LSB_full=1 -> four accepted, ifetch_ready=0 on the fifth, no strobes.
REQ-033 Then LSB_full=0, ROB_nextTag=3 -> LSB_enable and ROB_enable for four consecutive cycles, first issue_rdTag=3, FIFO order preserved.
REQ-034 Head ADD with RS_full=1 and a second entry LW -> no issue until RS_full=0; LW never overtakes.
REQ-035 Queue holding 3 entries, flush=1 for one cycle while ifetch_valid=1 -> count=0 next cycle, no strobes, input discarded.
REQ-036 Empty queue, ADD pushed: with DISPATCH_BYPASS_EN, RS_enable in the same cycle; without it, RS_enable one cycle later.
REQ-037 rst pulled low while count=2 and rdy=0 in a later cycle -> outputs 0 immediately; after release, count=0 and no stale issue.

Source files
------------

// File: rtl/dispatch_queue_pkg.sv
// Shared defines for the dispatch stage: op-type codes, booleans, ROB tag width
// and the default holding-queue depth.
package dispatch_queue_pkg;

  localparam int OPTYPE_W            = 6;
  localparam int ROB_TAG_W           = 4;
  localparam int DEFAULT_QUEUE_DEPTH = 4;

  localparam logic TRUE  = 1'b1;
  localparam logic FALSE = 1'b0;

  typedef logic [OPTYPE_W-1:0] optype_t;

  // Loads and stores occupy the contiguous range OP_LB..OP_SW.
  localparam optype_t OP_NOP   = 6'd0;
  localparam optype_t OP_LUI   = 6'd1;
  localparam optype_t OP_AUIPC = 6'd2;
  localparam optype_t OP_JAL   = 6'd3;
  localparam optype_t OP_JALR  = 6'd4;
  localparam optype_t OP_BEQ   = 6'd5;
  localparam optype_t OP_BNE   = 6'd6;
  localparam optype_t OP_BLT   = 6'd7;
  localparam optype_t OP_BGE   = 6'd8;
  localparam optype_t OP_BLTU  = 6'd9;
  localparam optype_t OP_BGEU  = 6'd10;
  localparam optype_t OP_LB    = 6'd11;
  localparam optype_t OP_LH    = 6'd12;
  localparam optype_t OP_LW    = 6'd13;
  localparam optype_t OP_LBU   = 6'd14;
  localparam optype_t OP_LHU   = 6'd15;
  localparam optype_t OP_SB    = 6'd16;
  localparam optype_t OP_SH    = 6'd17;
  localparam optype_t OP_SW    = 6'd18;
  localparam optype_t OP_ADDI  = 6'd19;
  localparam optype_t OP_SLTI  = 6'd20;
  localparam optype_t OP_SLTIU = 6'd21;
  localparam optype_t OP_XORI  = 6'd22;
  localparam optype_t OP_ORI   = 6'd23;
  localparam optype_t OP_ANDI  = 6'd24;
  localparam optype_t OP_SLLI  = 6'd25;
  localparam optype_t OP_SRLI  = 6'd26;
  localparam optype_t OP_SRAI  = 6'd27;
  localparam optype_t OP_ADD   = 6'd28;
  localparam optype_t OP_SUB   = 6'd29;
  localparam optype_t OP_SLL   = 6'd30;
  localparam optype_t OP_SLT   = 6'd31;
  localparam optype_t OP_SLTU  = 6'd32;
  localparam optype_t OP_XOR   = 6'd33;
  localparam optype_t OP_SRL   = 6'd34;
  localparam optype_t OP_SRA   = 6'd35;
  localparam optype_t OP_OR    = 6'd36;
  localparam optype_t OP_AND   = 6'd37;

  typedef enum logic {
    CLASS_RS  = 1'b0,
    CLASS_LSB = 1'b1
  } issue_class_t;

  function automatic issue_class_t classify(input optype_t op);
    if ((op >= OP_LB) && (op <= OP_SW)) begin
      return CLASS_LSB;
    end else begin
      return CLASS_RS;
    end
  endfunction

endpackage

// File: rtl/dispatch_fifo.sv
// Circular instruction holding FIFO: entry storage, head/tail pointers and an
// occupancy count one bit wider than the pointers so "full" is unambiguous.
module dispatch_fifo #(
  parameter  int DEPTH  = 4,
  parameter  int DATA_W = 70,
  localparam int PTR_W  = $clog2(DEPTH),
  localparam int CNT_W  = PTR_W + 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              i_en,
  input  logic              i_flush,
  input  logic              i_push,
  input  logic              i_pop,
  input  logic [DATA_W-1:0] i_wdata,
  output logic [DATA_W-1:0] o_head,
  output logic              o_full,
  output logic              o_empty
);

  logic [DATA_W-1:0] r_mem [DEPTH];
  logic [PTR_W-1:0]  r_head;
  logic [PTR_W-1:0]  r_tail;
  logic [CNT_W-1:0]  r_count;
  logic              w_do_push;
  logic              w_do_pop;

  assign o_full    = (r_count == CNT_W'(DEPTH));
  assign o_empty   = (r_count == {CNT_W{1'b0}});
  assign w_do_push = i_en && !i_flush && i_push && !o_full;
  assign w_do_pop  = i_en && !i_flush && i_pop && !o_empty;
  assign o_head    = r_mem[r_head];

  // Pointer and count update; pointers wrap naturally since DEPTH is a power of two.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_head  <= {PTR_W{1'b0}};
      r_tail  <= {PTR_W{1'b0}};
      r_count <= {CNT_W{1'b0}};
    end else if (i_en && i_flush) begin
      r_head  <= {PTR_W{1'b0}};
      r_tail  <= {PTR_W{1'b0}};
      r_count <= {CNT_W{1'b0}};
    end else begin
      if (w_do_push) begin
        r_tail <= r_tail + PTR_W'(1);
      end
      if (w_do_pop) begin
        r_head <= r_head + PTR_W'(1);
      end
      case ({w_do_push, w_do_pop})
        2'b10:   r_count <= r_count + CNT_W'(1);
        2'b01:   r_count <= r_count - CNT_W'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  // Entry storage; contents are only meaningful between head and tail.
  always_ff @(posedge clk) begin
    if (w_do_push) begin
      r_mem[r_tail] <= i_wdata;
    end
  end

endmodule

// File: rtl/dispatch_queue.sv
// In-order dispatch stage: buffers fetched instructions and issues the head to
// ROB/rename plus RS or LSB. Optional same-cycle bypass: DISPATCH_BYPASS_EN.
module dispatch_queue
  import dispatch_queue_pkg::*;
#(
  parameter int QUEUE_DEPTH = DEFAULT_QUEUE_DEPTH,
  parameter int PAYLOAD_W   = 64,
  parameter int TAG_W       = ROB_TAG_W
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 rdy,
  input  logic                 flush,
  input  logic                 ifetch_valid,
  input  logic [5:0]           ifetch_optype,
  input  logic [PAYLOAD_W-1:0] ifetch_payload,
  output logic                 ifetch_ready,
  input  logic                 ROB_full,
  input  logic                 RS_full,
  input  logic                 LSB_full,
  input  logic [TAG_W-1:0]     ROB_nextTag,
  output logic                 ROB_enable,
  output logic                 reg_rename_enable,
  output logic                 RS_enable,
  output logic                 LSB_enable,
  output logic [TAG_W-1:0]     issue_rdTag,
  output logic [5:0]           issue_optype,
  output logic [PAYLOAD_W-1:0] issue_payload
);

  localparam int ENTRY_W = OPTYPE_W + PAYLOAD_W;

  logic [ENTRY_W-1:0]   w_wdata;
  logic [ENTRY_W-1:0]   w_head;
  logic [5:0]           w_head_optype;
  logic [PAYLOAD_W-1:0] w_head_payload;
  logic                 w_full;
  logic                 w_empty;
  logic                 w_live;
  logic                 w_push_req;
  logic                 w_bypass;
  logic [5:0]           w_cand_optype;
  issue_class_t         w_cand_class;
  logic                 w_class_full;
  logic                 w_issue;

  assign w_wdata        = {ifetch_optype, ifetch_payload};
  assign w_head_optype  = w_head[ENTRY_W-1 -: OPTYPE_W];
  assign w_head_payload = w_head[PAYLOAD_W-1:0];

  // Acceptance depends only on registered occupancy and the control inputs.
  assign w_live       = rst && rdy && !flush;
  assign ifetch_ready = w_live && !w_full;
  assign w_push_req   = ifetch_valid && ifetch_ready;

`ifdef DISPATCH_BYPASS_EN
  logic w_in_class_full;
  assign w_in_class_full = (classify(ifetch_optype) == CLASS_LSB) ? LSB_full : RS_full;
  assign w_bypass        = w_empty && w_push_req && !ROB_full && !w_in_class_full;
`else
  assign w_bypass = FALSE;
`endif

  assign w_cand_optype = w_bypass ? ifetch_optype : w_head_optype;
  assign w_cand_class  = classify(w_cand_optype);

  // Select the occupancy flag of the unit the candidate instruction targets.
  always_comb begin
    w_class_full = TRUE;
    case (w_cand_class)
      CLASS_RS:  w_class_full = RS_full;
      CLASS_LSB: w_class_full = LSB_full;
      default:   w_class_full = TRUE;
    endcase
  end

  assign w_issue = w_live && !ROB_full && !w_class_full && (!w_empty || w_bypass);

  assign ROB_enable        = w_issue;
  assign reg_rename_enable = w_issue;
  assign RS_enable         = w_issue && (w_cand_class == CLASS_RS);
  assign LSB_enable        = w_issue && (w_cand_class == CLASS_LSB);
  assign issue_rdTag       = w_issue ? ROB_nextTag : {TAG_W{1'b0}};
  assign issue_optype      = w_cand_optype;
  assign issue_payload     = w_bypass ? ifetch_payload : w_head_payload;

  dispatch_fifo #(
    .DEPTH  (QUEUE_DEPTH),
    .DATA_W (ENTRY_W)
  ) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .i_en    (rdy),
    .i_flush (flush),
    .i_push  (w_push_req && !w_bypass),
    .i_pop   (w_issue && !w_bypass),
    .i_wdata (w_wdata),
    .o_head  (w_head),
    .o_full  (w_full),
    .o_empty (w_empty)
  );

endmodule

// File: tb/tb_dispatch_queue.sv
// Directed bench for dispatch_queue with a reference queue model as scoreboard.
module tb_dispatch_queue;
  import dispatch_queue_pkg::*;

  localparam int DEPTH = 4;
  localparam int PW    = 64;
  localparam int TW    = 4;

  logic          clk = 1'b0;
  logic          rst;
  logic          rdy;
  logic          flush;
  logic          ifetch_valid;
  logic [5:0]    ifetch_optype;
  logic [PW-1:0] ifetch_payload;
  logic          ifetch_ready;
  logic          ROB_full;
  logic          RS_full;
  logic          LSB_full;
  logic [TW-1:0] ROB_nextTag;
  logic          ROB_enable;
  logic          reg_rename_enable;
  logic          RS_enable;
  logic          LSB_enable;
  logic [TW-1:0] issue_rdTag;
  logic [5:0]    issue_optype;
  logic [PW-1:0] issue_payload;

  typedef struct {
    logic [5:0]    op;
    logic [PW-1:0] pl;
  } ent_t;

  ent_t sb[$];
  int   checks   = 0;
  int   failures = 0;

  always #5 clk = ~clk;

  dispatch_queue #(
    .QUEUE_DEPTH (DEPTH),
    .PAYLOAD_W   (PW),
    .TAG_W       (TW)
  ) dut (
    .clk               (clk),
    .rst               (rst),
    .rdy               (rdy),
    .flush             (flush),
    .ifetch_valid      (ifetch_valid),
    .ifetch_optype     (ifetch_optype),
    .ifetch_payload    (ifetch_payload),
    .ifetch_ready      (ifetch_ready),
    .ROB_full          (ROB_full),
    .RS_full           (RS_full),
    .LSB_full          (LSB_full),
    .ROB_nextTag       (ROB_nextTag),
    .ROB_enable        (ROB_enable),
    .reg_rename_enable (reg_rename_enable),
    .RS_enable         (RS_enable),
    .LSB_enable        (LSB_enable),
    .issue_rdTag       (issue_rdTag),
    .issue_optype      (issue_optype),
    .issue_payload     (issue_payload)
  );

  function automatic bit is_lsb(input logic [5:0] op);
    return (op >= 6'd11) && (op <= 6'd18);
  endfunction

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic drive(input logic v, input logic [5:0] op, input logic [PW-1:0] pl);
    ifetch_valid   = v;
    ifetch_optype  = op;
    ifetch_payload = pl;
  endtask

  // One clock: predict from the model, compare mid-cycle, update the model, advance.
  task automatic step();
    bit            exp_ready;
    bit            exp_issue;
    bit            exp_lsb;
    bit            byp;
    logic [5:0]    eop;
    logic [PW-1:0] epl;
    ent_t          e;
    #2;
    exp_ready = rst && rdy && !flush && (sb.size() < DEPTH);
    byp = 1'b0;
`ifdef DISPATCH_BYPASS_EN
    byp = (sb.size() == 0) && ifetch_valid && exp_ready && !ROB_full &&
          !(is_lsb(ifetch_optype) ? LSB_full : RS_full);
`endif
    if (sb.size() > 0) begin
      eop = sb[0].op;
      epl = sb[0].pl;
    end else begin
      eop = ifetch_optype;
      epl = ifetch_payload;
    end
    exp_lsb   = is_lsb(eop);
    exp_issue = rst && rdy && !flush && !ROB_full && !(exp_lsb ? LSB_full : RS_full) &&
                ((sb.size() > 0) || byp);
    chk("ifetch_ready", 64'(ifetch_ready), 64'(exp_ready));
    chk("ROB_enable", 64'(ROB_enable), 64'(exp_issue));
    chk("reg_rename_enable", 64'(reg_rename_enable), 64'(exp_issue));
    chk("RS_enable", 64'(RS_enable), 64'(exp_issue && !exp_lsb));
    chk("LSB_enable", 64'(LSB_enable), 64'(exp_issue && exp_lsb));
    chk("issue_rdTag", 64'(issue_rdTag), exp_issue ? 64'(ROB_nextTag) : 64'd0);
    if (exp_issue) begin
      chk("issue_optype", 64'(issue_optype), 64'(eop));
      chk("issue_payload", issue_payload, epl);
    end
    if (!rst) begin
      sb.delete();
    end else if (rdy) begin
      if (flush) begin
        sb.delete();
      end else begin
        if (exp_issue && !byp) sb.delete(0);
        if (ifetch_valid && exp_ready && !byp) begin
          e.op = ifetch_optype;
          e.pl = ifetch_payload;
          sb.push_back(e);
        end
      end
    end
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst = 1'b0; rdy = 1'b1; flush = 1'b0;
    ROB_full = 1'b0; RS_full = 1'b0; LSB_full = 1'b0; ROB_nextTag = 4'd5;
    drive(1'b1, OP_ADD, 64'hDEAD);
    step();
    step();
    rst = 1'b1;
    drive(1'b0, OP_NOP, 64'h0);
    step();

    // Five loads against a full LSB: four accepted, fifth refused.
    LSB_full = 1'b1; ROB_nextTag = 4'd3;
    for (int i = 0; i < 5; i++) begin
      drive(1'b1, OP_LB, 64'h1000 + 64'(i));
      step();
    end
    // Drain in order with changing tags.
    drive(1'b0, OP_NOP, 64'h0);
    LSB_full = 1'b0;
    for (int i = 0; i < 4; i++) begin
      ROB_nextTag = 4'(3 + i);
      step();
    end
    step();

    // Stalled ADD head must block the younger LW.
    RS_full = 1'b1; ROB_nextTag = 4'd9;
    drive(1'b1, OP_ADD, 64'h2000);
    step();
    drive(1'b1, OP_LW, 64'h2001);
    step();
    drive(1'b0, OP_NOP, 64'h0);
    step();
    step();
    RS_full = 1'b0;
    step();
    step();
    step();

    // Full queue refuses a push even while issuing; push+issue keeps count.
    LSB_full = 1'b1;
    for (int i = 0; i < 4; i++) begin
      drive(1'b1, OP_SW, 64'h3000 + 64'(i));
      step();
    end
    LSB_full = 1'b0; ROB_full = 1'b1;
    drive(1'b1, OP_SW, 64'h3004);
    step();
    ROB_full = 1'b0;
    step();
    drive(1'b1, OP_SB, 64'h3005);
    step();
    drive(1'b0, OP_NOP, 64'h0);
    for (int i = 0; i < 5; i++) step();

    // Flush with three queued and a valid input.
    LSB_full = 1'b1;
    for (int i = 0; i < 3; i++) begin
      drive(1'b1, OP_LH, 64'h4000 + 64'(i));
      step();
    end
    LSB_full = 1'b0; flush = 1'b1;
    drive(1'b1, OP_LW, 64'h4FFF);
    step();
    flush = 1'b0;
    drive(1'b0, OP_NOP, 64'h0);
    step();
    step();

    // Empty queue, single ADD: bypass-dependent latency.
    ROB_nextTag = 4'd12;
    drive(1'b1, OP_ADD, 64'h5000);
    step();
    drive(1'b0, OP_NOP, 64'h0);
    step();
    step();

    // Reset while two entries are held and rdy is low.
    LSB_full = 1'b1;
    drive(1'b1, OP_LB, 64'h6000);
    step();
    drive(1'b1, OP_LBU, 64'h6001);
    step();
    drive(1'b0, OP_NOP, 64'h0);
    rdy = 1'b0;
    step();
    rst = 1'b0;
    step();
    rdy = 1'b1; LSB_full = 1'b0;
    step();
    rst = 1'b1;
    step();
    step();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
